iter_muldiv_unit: RTL and testbench

//  Multi-cycle unsigned multiply/divide unit of the 16-bit datapath. Takes the two

---
 rtl/iter_muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_iter_muldiv_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/iter_muldiv_unit.sv
// iter_muldiv_unit
//   Multi-cycle unsigned multiply/divide unit sitting beside the single-cycle ALU.
//   It accepts two register-file operands, iterates one bit per clock
//   (shift-add for multiply, restoring shift-subtract for divide) and presents
//   a single write-back strobe with the destination register index and result.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous reset, active-high (priority over start)
//   start     request, accepted only while busy=0
//   op        00 MUL_LO, 01 MUL_HI, 10 DIV_Q, 11 DIV_R
//   a_in      multiplicand / dividend
//   b_in      multiplier / divisor
//   dest_reg  destination register index
//   busy      high while an operation is in flight (RUN and WB)
//   wb_we     one-cycle write strobe
//   wb_reg    destination index, qualified by wb_we
//   wb_data   result, qualified by wb_we
module iter_muldiv_unit #(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [WIDTH-1:0]      a_in,
  input  logic [WIDTH-1:0]      b_in,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  output logic                  busy,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_reg,
  output logic [WIDTH-1:0]      wb_data
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [1:0]              op_q;
  logic [REG_ADDR_W-1:0]   dest_q;

  // Shared iteration registers:
  //   multiply: hi = running partial product (one carry bit), lo = multiplier
  //             shifting out / product low half shifting in, opnd = multiplicand
  //   divide:   hi = partial remainder, lo = dividend shifting out / quotient
  //             shifting in, opnd = divisor
  logic [WIDTH:0]          hi;
  logic [WIDTH-1:0]        lo;
  logic [WIDTH-1:0]        opnd;

  logic [2*WIDTH:0]        step;
  logic [WIDTH:0]          hi_n;
  logic [WIDTH-1:0]        lo_n;
  logic [WIDTH-1:0]        result;
  logic                    last_step;

  // One shift-add step: conditionally add the multiplicand into the upper
  // half, then shift the whole {hi, lo} pair right by one.
  function automatic logic [2*WIDTH:0] mul_step(input logic [WIDTH:0]   h,
                                                input logic [WIDTH-1:0] l,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] t;
    sum = l[0] ? (h + {1'b0, m}) : h;
    t   = {sum, l} >> 1;
    return t;
  endfunction

  // One restoring divide step. The partial remainder is always below the
  // divisor, so the trial difference's top bit is a reliable borrow flag.
  // A zero divisor never borrows, which naturally yields an all-ones quotient
  // and a remainder equal to the dividend.
  function automatic logic [2*WIDTH:0] div_step(input logic [WIDTH:0]   h,
                                                input logic [WIDTH-1:0] l,
                                                input logic [WIDTH-1:0] d);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    shifted = {h[WIDTH-1:0], l[WIDTH-1]};
    trial   = shifted - {1'b0, d};
    if (!trial[WIDTH]) begin
      return {trial, l[WIDTH-2:0], 1'b1};
    end
    return {shifted, l[WIDTH-2:0], 1'b0};
  endfunction

  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    step   = op_q[1] ? div_step(hi, lo, opnd) : mul_step(hi, lo, opnd);
    hi_n   = step[2*WIDTH:WIDTH];
    lo_n   = step[WIDTH-1:0];
    // MUL_HI and DIV_R live in the upper register, MUL_LO and DIV_Q in the lower.
    result = op_q[0] ? hi_n[WIDTH-1:0] : lo_n;
  end

  // ---- control: state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    wb_we     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_step) state_nxt = S_WB;
      end
      S_WB: begin
        busy      = 1'b1;
        wb_we     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- datapath: operand latch, iteration, result capture ----
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      op_q    <= '0;
      dest_q  <= '0;
      hi      <= '0;
      lo      <= '0;
      opnd    <= '0;
      wb_reg  <= '0;
      wb_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q   <= op;
            dest_q <= dest_reg;
            hi     <= '0;
            lo     <= op[1] ? a_in : b_in;
            opnd   <= op[1] ? b_in : a_in;
            cnt    <= '0;
          end
        end
        S_RUN: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            wb_data <= result;
            wb_reg  <= dest_q;
          end
        end
        S_WB: begin
          cnt <= '0;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_muldiv_unit.sv
module tb_iter_muldiv_unit;

  localparam int WIDTH = 16;
  localparam int RW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [RW-1:0]    dest_reg;
  logic             busy;
  logic             wb_we;
  logic [RW-1:0]    wb_reg;
  logic [WIDTH-1:0] wb_data;

  iter_muldiv_unit #(.WIDTH(WIDTH), .REG_ADDR_W(RW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .dest_reg (dest_reg),
    .busy     (busy),
    .wb_we    (wb_we),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] exp_data_q[$];
  logic [RW-1:0]    exp_reg_q[$];
  int               exp_cyc_q[$];
  logic             prev_we = 1'b0;

  // Reference: plain arithmetic on the full-width product / quotient.
  function automatic logic [WIDTH-1:0] ref_result(input logic [1:0] o,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    case (o)
      2'b00:   return p[WIDTH-1:0];
      2'b01:   return p[2*WIDTH-1:WIDTH];
      2'b10:   return (b == 0) ? {WIDTH{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write-back strobe is matched against the scoreboard.
  always @(negedge clk) begin
    if (wb_we === 1'b1) begin
      check("wb_we_gap", {31'b0, prev_we}, 32'd0);
      if (exp_data_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_wb: strobe with nothing pending, reg=%0d data=0x%0h cycle %0d",
                 wb_reg, wb_data, cyc);
      end else begin
        check("wb_data",  32'(wb_data), 32'(exp_data_q.pop_front()));
        check("wb_reg",   32'(wb_reg),  32'(exp_reg_q.pop_front()));
        check("wb_cycle", cyc,          exp_cyc_q.pop_front());
      end
    end
    prev_we = wb_we;
  end

  // Issue one op at the current falling edge (busy must be 0), optionally
  // pulse ignored starts at cycles 5 and 10, and return at the falling edge
  // of the first idle cycle after write-back.
  task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [RW-1:0] d,
                        input bit ign);
    int bc;
    bc       = 0;
    op       = o;
    a_in     = a;
    b_in     = b;
    dest_reg = d;
    start    = 1'b1;
    exp_data_q.push_back(ref_result(o, a, b));
    exp_reg_q.push_back(d);
    exp_cyc_q.push_back(cyc + WIDTH + 1);
    @(posedge clk);
    #1;
    start    = 1'b0;
    a_in     = WIDTH'($urandom);
    b_in     = WIDTH'($urandom);
    op       = 2'($urandom);
    dest_reg = RW'($urandom);
    for (int k = 1; k <= WIDTH + 10; k++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
      if (ign && (k == 5 || k == 10)) begin
        start    = 1'b1;
        a_in     = WIDTH'($urandom);
        b_in     = WIDTH'($urandom);
        op       = 2'($urandom);
        dest_reg = RW'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("busy_cycles", bc, WIDTH + 1);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    a_in     = '0;
    b_in     = '0;
    dest_reg = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_wb_we",   32'(wb_we),   32'd0);
    check("rst_wb_reg",  32'(wb_reg),  32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(2'b00, 16'h0003, 16'h0005, 4'd4, 1'b0);
    run_op(2'b01, 16'hFFFF, 16'hFFFF, 4'd1, 1'b0);
    run_op(2'b00, 16'hFFFF, 16'hFFFF, 4'd2, 1'b0);
    run_op(2'b10, 16'd1000, 16'd10,   4'd3, 1'b0);
    run_op(2'b11, 16'h7FF0, 16'd1000, 4'd5, 1'b0);
    run_op(2'b10, 16'h1234, 16'h0000, 4'd6, 1'b0);
    run_op(2'b11, 16'h1234, 16'h0000, 4'd7, 1'b0);

    // Ignored starts during busy, then a back-to-back op in the first idle cycle.
    run_op(2'b00, 16'h0002, 16'h0003, 4'd8, 1'b1);
    run_op(2'b01, 16'hABCD, 16'h1234, 4'd9, 1'b0);

    // Abort in the middle of RUN: no strobe may follow for this op.
    op       = 2'b00;
    a_in     = 16'h0007;
    b_in     = 16'h0009;
    dest_reg = 4'd10;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy",    32'(busy),    32'd0);
    check("abort_wb_data", 32'(wb_data), 32'd0);
    rst = 1'b0;
    repeat (WIDTH + 4) @(negedge clk);
    run_op(2'b10, 16'hBEEF, 16'h0123, 4'd11, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) rb = rb & 16'h00FF;
      run_op(2'($urandom), ra, rb, RW'($urandom), bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int t = 0; t < 50 && exp_data_q.size() != 0; t++) @(negedge clk);
    check("queue_drained", exp_data_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
